// File: rtl/async_fifo_wr_front_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_front_pkg
// Shared types and helpers for the async-FIFO write-side ingress stage.
//   wr_front_state_e : occupancy of the 2-entry skid pipeline
//   CNTW_DEFAULT     : default width of the statistics counters
//   sat_inc_en       : increment-enable for a saturating counter
// -----------------------------------------------------------------------------
package async_fifo_wr_front_pkg;

   // Pipeline occupancy: EMPTY (nothing held), ONE (output register only),
   // TWO (output and skid registers both full, upstream is back-pressured).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } wr_front_state_e;

   localparam int CNTW_DEFAULT = 16;

   // A saturating counter only steps when asked to and not already pinned at
   // all-ones; the caller supplies the all-ones compare for its own width.
   function automatic logic sat_inc_en(input logic inc, input logic atMax);
      return inc & ~atMax;
   endfunction

endpackage

// File: rtl/async_fifo_wr_front_skid_buf_2.sv
// -----------------------------------------------------------------------------
// skid_buf_2
// Two-entry valid/ready register pair. The head entry (output register) is
// presented downstream; a second (skid) entry absorbs one extra beat so that
// o_ready depends only on registered occupancy, never on i_take.
// Ports:
//   wclk, wrst_n : clock, asynchronous active-low reset
//   i_valid      : upstream beat valid
//   o_ready      : upstream ready (low only when both entries are full)
//   i_data       : upstream beat
//   i_take       : downstream consumes the head entry this cycle
//   o_valid      : head entry holds a beat
//   o_data       : head entry contents (0 after reset)
// -----------------------------------------------------------------------------
module skid_buf_2
   import async_fifo_wr_front_pkg::*;
#(
   parameter int W = 33
) (
   input  logic         wclk,
   input  logic         wrst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   input  logic         i_take,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   wr_front_state_e r_state;
   wr_front_state_e w_stateNext;
   logic [W-1:0]    r_outData;
   logic [W-1:0]    r_skData;
   logic            w_fire;
   logic            w_take;
   logic            w_loadOut;
   logic            w_outFromSkid;
   logic            w_loadSkid;

   assign o_ready = (r_state != TWO);
   assign o_valid = (r_state != EMPTY);
   assign o_data  = r_outData;
   assign w_fire  = i_valid & o_ready;
   // A take is only meaningful when the head actually holds a beat.
   assign w_take  = i_take & o_valid;

   // Occupancy register.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next occupancy and which data register loads from where. When a new beat
   // arrives in ONE while the head is being consumed, it goes straight into
   // the head register so the skid entry is only used under back-pressure.
   always_comb begin
      w_stateNext   = r_state;
      w_loadOut     = 1'b0;
      w_outFromSkid = 1'b0;
      w_loadSkid    = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_fire) begin
               w_loadOut   = 1'b1;
               w_stateNext = ONE;
            end
         end
         ONE: begin
            if (w_fire && w_take) begin
               w_loadOut = 1'b1;
            end else if (w_fire) begin
               w_loadSkid  = 1'b1;
               w_stateNext = TWO;
            end else if (w_take) begin
               w_stateNext = EMPTY;
            end
         end
         TWO: begin
            if (w_take) begin
               w_outFromSkid = 1'b1;
               w_stateNext   = ONE;
            end
         end
         default: begin
            w_stateNext = EMPTY;
         end
      endcase
   end

   // Data registers load only on their load strobes; reset to 0 so an idle
   // head never exposes unknown upstream data.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_outData <= '0;
         r_skData  <= '0;
      end else begin
         if (w_loadOut) begin
            r_outData <= i_data;
         end else if (w_outFromSkid) begin
            r_outData <= r_skData;
         end
         if (w_loadSkid) begin
            r_skData <= i_data;
         end
      end
   end

endmodule

// File: rtl/async_fifo_wr_front.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_front
// Write-side ingress stage in front of the async-FIFO write-pointer/full block.
// Turns a valid/ready beat stream into the FIFO's winc/wdata strobe, gated by
// the registered wfull, and keeps write-domain statistics.
// Ports:
//   wclk, wrst_n     : write clock, asynchronous active-low reset
//   s_valid/s_ready  : upstream beat handshake (s_ready is registered state)
//   s_data, s_last   : upstream payload and end-of-packet flag
//   wfull            : registered full flag from the write-pointer block
//   winc             : FIFO write strobe / memory write-enable
//   wdata            : {last, data} written with winc
//   clr_stats        : synchronous clear of all counters (wins over increments)
//   beat_cnt         : committed beats (wraps)
//   pkt_cnt          : committed beats with last set (wraps)
//   stall_cnt        : cycles a held beat was blocked by wfull (saturates)
// -----------------------------------------------------------------------------
module async_fifo_wr_front
   import async_fifo_wr_front_pkg::*;
#(
   parameter int DSIZE = 32,
   parameter int CNTW  = CNTW_DEFAULT
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DSIZE-1:0] s_data,
   input  logic             s_last,
   input  logic             wfull,
   output logic             winc,
   output logic [DSIZE:0]   wdata,
   input  logic             clr_stats,
   output logic [CNTW-1:0]  beat_cnt,
   output logic [CNTW-1:0]  pkt_cnt,
   output logic [CNTW-1:0]  stall_cnt
);

   logic            w_outVld;
   logic [DSIZE:0]  w_outWord;
   logic            w_winc;
   logic            w_outLast;
   logic            w_stallInc;
   logic [CNTW-1:0] r_beatCnt;
   logic [CNTW-1:0] r_pktCnt;
   logic [CNTW-1:0] r_stallCnt;

   skid_buf_2 #(
      .W (DSIZE + 1)
   ) u_skid (
      .wclk    (wclk),
      .wrst_n  (wrst_n),
      .i_valid (s_valid),
      .o_ready (s_ready),
      .i_data  ({s_last, s_data}),
      .i_take  (w_winc),
      .o_valid (w_outVld),
      .o_data  (w_outWord)
   );

   // Commit only when the FIFO is not full, so winc can never coincide with
   // wfull regardless of the pointer block's own gating.
   assign w_winc     = w_outVld & ~wfull;
   assign w_outLast  = w_outWord[DSIZE];
   assign w_stallInc = sat_inc_en(w_outVld & wfull, &r_stallCnt);

   assign winc      = w_winc;
   assign wdata     = w_outWord;
   assign beat_cnt  = r_beatCnt;
   assign pkt_cnt   = r_pktCnt;
   assign stall_cnt = r_stallCnt;

   // Statistics: beat/packet counters wrap, the stall counter pins at
   // all-ones, and a clear request overrides any increment in that cycle.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_beatCnt  <= '0;
         r_pktCnt   <= '0;
         r_stallCnt <= '0;
      end else if (clr_stats) begin
         r_beatCnt  <= '0;
         r_pktCnt   <= '0;
         r_stallCnt <= '0;
      end else begin
         r_beatCnt  <= r_beatCnt + CNTW'(w_winc);
         r_pktCnt   <= r_pktCnt + CNTW'(w_winc & w_outLast);
         r_stallCnt <= r_stallCnt + CNTW'(w_stallInc);
      end
   end

endmodule
